// File: rtl/xxd_pkg.sv
// Shared types and helpers for the xxd byte-stream delay line.
package xxd_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 256;

  typedef enum logic [1:0] {
    MODE_RUN,
    MODE_ARM,
    MODE_REPLAY
  } mode_e;

  // Requested delay limited to the usable range 1..depth.
  function automatic int unsigned clamp_delay(input int unsigned req,
                                              input int unsigned depth);
    int unsigned d;
    if (req == 0) d = 1;
    else if (req > depth) d = depth;
    else d = req;
    return d;
  endfunction

endpackage

// File: rtl/xxd_dpram.sv
// Simple dual-port RAM: one write port, one registered read port.
// A read and a write to the same address in one cycle return the old contents.
module xxd_dpram
  import xxd_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
    if (we) mem[waddr] <= wdata;
  end

endmodule

// File: rtl/xxd_delay_line.sv
// Programmable-delay byte stream delay line on a circular RAM buffer,
// with zero-fill for unfilled history and a freeze/replay loop of the last D samples.
//
// state        | meaning
// MODE_RUN     | normal delay operation, inputs accepted while freeze low
// MODE_ARM     | freeze seen, replay pointer loaded, first replay read issued
// MODE_REPLAY  | looping reads over the last D samples
module xxd_delay_line
  import xxd_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             cfg_load,
  input  logic [AW:0]      cfg_delay,
  input  logic             flush,
  input  logic             freeze,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [AW:0]      fill,
  output logic             primed
);

  localparam int DW = AW + 1;
  localparam logic [DW-1:0] DEPTH_D = DW'(DEPTH);

  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [DW-1:0]    delay;
  logic [DW-1:0]    k;
  mode_e            mode;
  logic             out_valid_q;
  logic             zero_q;
  logic [WIDTH-1:0] rdata;

  logic             accept;
  logic             cfg_take;
  logic             clr;
  logic             replay_rd;
  logic [DW-1:0]    d_cfg;
  logic [DW-1:0]    d_eff;
  logic [DW-1:0]    fill_base;
  logic [DW-1:0]    fill_inc;
  logic [DW-1:0]    gap;
  logic [DW-1:0]    k_next;
  logic             zero_acc;
  logic             zero_rep;
  logic [AW-1:0]    raddr;

  assign in_ready = !freeze;
  assign accept   = in_valid & !freeze;
  assign cfg_take = cfg_load & !freeze;
  assign clr      = cfg_take | flush;

  // A new delay or a clear in the same cycle as an accept applies before it.
  assign d_cfg     = DW'(clamp_delay(32'(cfg_delay), DEPTH));
  assign d_eff     = cfg_take ? d_cfg : delay;
  assign fill_base = clr ? '0 : fill;
  assign fill_inc  = (fill_base >= d_eff) ? d_eff : fill_base + 1'b1;
  assign zero_acc  = fill_base < d_eff;

  // Replay slots older than the filled history were never written.
  assign gap       = delay - fill;
  assign zero_rep  = k < gap;
  assign k_next    = (k == delay - 1'b1) ? '0 : k + 1'b1;

  assign replay_rd = freeze & (mode != MODE_RUN);
  assign raddr     = replay_rd ? rp + k[AW-1:0] : wp - d_eff[AW-1:0];

  xxd_dpram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (wp),
    .wdata (in_data),
    .re    (accept | replay_rd),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp          <= '0;
      rp          <= '0;
      delay       <= DEPTH_D;
      fill        <= '0;
      k           <= '0;
      mode        <= MODE_RUN;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b1;
    end else begin
      out_valid_q <= accept | replay_rd;
      if (accept) zero_q <= zero_acc;
      else if (replay_rd) zero_q <= zero_rep;

      if (cfg_take) delay <= d_cfg;

      if (accept) begin
        wp   <= wp + 1'b1;
        fill <= fill_inc;
      end else if (clr) begin
        fill <= '0;
      end

      if (!freeze) begin
        mode <= MODE_RUN;
      end else begin
        case (mode)
          MODE_RUN: begin
            mode <= MODE_ARM;
            rp   <= wp - delay[AW-1:0];
            k    <= '0;
          end
          MODE_ARM, MODE_REPLAY: begin
            mode <= MODE_REPLAY;
            k    <= k_next;
          end
          default: mode <= MODE_RUN;
        endcase
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = (out_valid_q && !zero_q) ? rdata : '0;
  assign primed    = (fill == delay);

endmodule

// File: tb/tb_xxd_delay_line.sv
// Directed bench for xxd_delay_line (DEPTH=8) with a queue scoreboard on the output stream.
module tb_xxd_delay_line;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int DW    = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             cfg_load = 1'b0;
  logic [DW-1:0]    cfg_delay = '0;
  logic             flush = 1'b0;
  logic             freeze = 1'b0;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [DW-1:0]    fill;
  logic             primed;

  int n_vec = 0;
  int n_err = 0;
  logic [WIDTH-1:0] exp_q[$];

  xxd_delay_line #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .cfg_load  (cfg_load),
    .cfg_delay (cfg_delay),
    .flush     (flush),
    .freeze    (freeze),
    .out_valid (out_valid),
    .out_data  (out_data),
    .fill      (fill),
    .primed    (primed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_in(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] e);
    in_valid = 1'b1;
    in_data  = d;
    exp_q.push_back(e);
    step();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = 8'h99;
    step();
  endtask

  // Monitor: every presented output must match the next expected sample.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out: got valid data 0x%0h expected no output at %0t",
                 out_data, $time);
      end else begin
        check("out_data", int'(out_data), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    rst_n = 1'b1;
    #1;
    check("rst_fill", int'(fill), 0);
    check("rst_primed", int'(primed), 0);
    check("rst_in_ready", int'(in_ready), 1);

    // Default delay 8: eight zeros, then the stream delayed by 8.
    for (int i = 1; i <= 20; i++) begin
      push_in(8'(i), (i <= 8) ? 8'h00 : 8'(i - 8));
      check("t1_primed", int'(primed), (i >= 8) ? 1 : 0);
      check("t1_fill", int'(fill), (i < 8) ? i : 8);
    end

    // Delay 3 after reconfiguration.
    in_valid = 1'b0;
    cfg_load = 1'b1;
    cfg_delay = 4'd3;
    step();
    cfg_load = 1'b0;
    check("t2_fill_clr", int'(fill), 0);
    push_in(8'h10, 8'h00);
    push_in(8'h11, 8'h00);
    push_in(8'h12, 8'h00);
    push_in(8'h13, 8'h10);
    push_in(8'h14, 8'h11);
    push_in(8'h15, 8'h12);
    check("t2_fill", int'(fill), 3);
    check("t2_primed", int'(primed), 1);

    // cfg_delay=0 clamps to 1, loaded together with an accept.
    cfg_load = 1'b1;
    cfg_delay = 4'd0;
    push_in(8'h20, 8'h00);
    cfg_load = 1'b0;
    check("t3_fill_after_sim", int'(fill), 1);
    push_in(8'h21, 8'h20);
    push_in(8'h22, 8'h21);
    check("t3_fill_d1", int'(fill), 1);

    // cfg_delay=15 clamps to 8: read collides with write, old data returned.
    in_valid = 1'b0;
    cfg_load = 1'b1;
    cfg_delay = 4'd15;
    step();
    cfg_load = 1'b0;
    check("t3_fill_clr", int'(fill), 0);
    check("t3_primed_clr", int'(primed), 0);
    for (int i = 0; i < 16; i++) push_in(8'(8'h30 + i), (i < 8) ? 8'h00 : 8'(8'h30 + i - 8));
    check("t3_primed_d8", int'(primed), 1);

    // Delay 2 with gapped input.
    in_valid = 1'b0;
    cfg_load = 1'b1;
    cfg_delay = 4'd2;
    step();
    cfg_load = 1'b0;
    push_in(8'h41, 8'h00);
    idle();
    push_in(8'h42, 8'h00);
    idle();
    push_in(8'h43, 8'h41);
    idle();
    push_in(8'h44, 8'h42);
    idle();

    // Delay 4, five samples, then a 10-cycle freeze.
    cfg_load = 1'b1;
    cfg_delay = 4'd4;
    step();
    cfg_load = 1'b0;
    push_in(8'hA1, 8'h00);
    push_in(8'hA2, 8'h00);
    push_in(8'hA3, 8'h00);
    push_in(8'hA4, 8'h00);
    push_in(8'hA5, 8'hA1);
    freeze = 1'b1;
    in_valid = 1'b1;
    in_data = 8'hEE;
    #1;
    check("t5_in_ready", int'(in_ready), 0);
    for (int i = 0; i < 9; i++) exp_q.push_back(8'(8'hA2 + (i % 4)));
    for (int i = 0; i < 10; i++) begin
      step();
      check("t5_in_ready", int'(in_ready), 0);
    end
    freeze = 1'b0;
    push_in(8'hA6, 8'hA2);
    push_in(8'hA7, 8'hA3);
    check("t5_fill", int'(fill), 4);

    // Only two accepts after flush, then freeze: stale slots replay as zero.
    in_valid = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t6_fill_flush", int'(fill), 0);
    push_in(8'hB1, 8'h00);
    push_in(8'hB2, 8'h00);
    in_valid = 1'b0;
    freeze = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hB1);
    repeat (4) step();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_out_valid", int'(out_valid), 0);
    check("t6_rst_out_data", int'(out_data), 0);
    check("t6_rst_fill", int'(fill), 0);
    check("t6_rst_primed", int'(primed), 0);
    freeze = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step();
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no end of test expected finish before 20000");
    $fatal(1);
  end

endmodule
